// File: rtl/usb_fs_rx.sv
// Full-speed USB receive front end: pad synchronizer, DPLL-style bit sampler,
// NRZI decode, bit destuffing, SYNC/EOP framing and bus-reset detection.
module usb_fs_rx #(
    parameter int RESET_CYCLES = 120
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       usb_d_p,
    input  logic       usb_d_n,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       bus_reset
);

    localparam int CNT_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [CNT_W-1:0] RESET_LIMIT = CNT_W'(RESET_CYCLES);

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ABORT
    } state_t;

    // Synchronizer and bit sampler
    logic             r_dp_meta, r_dp_sync;
    logic             r_dn_meta, r_dn_sync;
    logic [1:0]       r_line_prev;
    logic [1:0]       r_phase;
    logic             r_prev_j;
    logic [CNT_W-1:0] r_se0_cnt;

    logic [1:0] w_line;
    logic [1:0] w_phase;
    logic       w_sample;
    logic       w_is_j, w_is_k, w_is_se0;
    logic       w_bit;

    // Framing FSM and datapath
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_ones;
    logic [1:0] r_zeros;
    logic       r_se0_seen;
    logic       r_rx_active;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;
    logic       r_rx_eop;
    logic       r_rx_error;

    state_t     w_state_next;
    logic [7:0] w_shift_next;
    logic [2:0] w_bit_cnt_next;
    logic [2:0] w_ones_next;
    logic [1:0] w_zeros_next;
    logic       w_se0_seen_next;
    logic       w_active_next;
    logic       w_valid_next;
    logic [7:0] w_data_next;
    logic       w_eop_next;
    logic       w_error_next;

    assign w_line   = {r_dp_sync, r_dn_sync};
    assign w_is_j   = (w_line == LINE_J);
    assign w_is_k   = (w_line == LINE_K);
    assign w_is_se0 = (w_line == LINE_SE0);

    // Phase realigns on every line transition so the sample lands mid-bit.
    assign w_phase  = (w_line != r_line_prev) ? 2'd0 : r_phase + 2'd1;
    assign w_sample = (w_phase == 2'd2);
    assign w_bit    = (w_is_j == r_prev_j);

    always_ff @(posedge sys_clk) begin
        // NOTE: every register uses <= so all flops update from pre-edge values.
        if (sys_rst) begin
            r_dp_meta   <= 1'b1;
            r_dp_sync   <= 1'b1;
            r_dn_meta   <= 1'b0;
            r_dn_sync   <= 1'b0;
            r_line_prev <= LINE_J;
            r_phase     <= 2'd0;
            r_prev_j    <= 1'b1;
        end else begin
            r_dp_meta   <= usb_d_p;
            r_dp_sync   <= r_dp_meta;
            r_dn_meta   <= usb_d_n;
            r_dn_sync   <= r_dn_meta;
            r_line_prev <= w_line;
            r_phase     <= w_phase;
            if (w_sample && (w_is_j || w_is_k)) begin
                r_prev_j <= w_is_j;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_se0_cnt <= '0;
        end else if (w_is_se0) begin
            if (r_se0_cnt != RESET_LIMIT) begin
                r_se0_cnt <= r_se0_cnt + CNT_W'(1);
            end
        end else begin
            r_se0_cnt <= '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_ones      <= 3'd0;
            r_zeros     <= 2'd0;
            r_se0_seen  <= 1'b0;
            r_rx_active <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_eop    <= 1'b0;
            r_rx_error  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_ones      <= w_ones_next;
            r_zeros     <= w_zeros_next;
            r_se0_seen  <= w_se0_seen_next;
            r_rx_active <= w_active_next;
            r_rx_valid  <= w_valid_next;
            r_rx_data   <= w_data_next;
            r_rx_eop    <= w_eop_next;
            r_rx_error  <= w_error_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_ones_next     = r_ones;
        w_zeros_next    = r_zeros;
        w_se0_seen_next = r_se0_seen;
        w_active_next   = r_rx_active;
        w_valid_next    = 1'b0;
        w_data_next     = r_rx_data;
        w_eop_next      = 1'b0;
        w_error_next    = 1'b0;

        if (w_sample) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_k) begin
                        w_state_next = S_SYNC;
                        w_zeros_next = 2'd0;
                    end
                end

                S_SYNC: begin
                    if (w_is_j || w_is_k) begin
                        if (!w_bit) begin
                            w_zeros_next = (r_zeros == 2'd3) ? 2'd3 : r_zeros + 2'd1;
                        end else if (r_zeros == 2'd3) begin
                            w_state_next   = S_DATA;
                            w_active_next  = 1'b1;
                            w_bit_cnt_next = 3'd0;
                            w_ones_next    = 3'd0;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end

                S_DATA: begin
                    if (w_is_j || w_is_k) begin
                        if (r_ones == 3'd6) begin
                            // Six ones must be followed by a stuffed zero, which is dropped.
                            if (!w_bit) begin
                                w_ones_next = 3'd0;
                            end else begin
                                w_error_next    = 1'b1;
                                w_active_next   = 1'b0;
                                w_se0_seen_next = 1'b0;
                                w_state_next    = S_ABORT;
                            end
                        end else begin
                            w_shift_next   = {w_bit, r_shift[7:1]};
                            w_bit_cnt_next = r_bit_cnt + 3'd1;
                            w_ones_next    = w_bit ? r_ones + 3'd1 : 3'd0;
                            if (r_bit_cnt == 3'd7) begin
                                w_valid_next = 1'b1;
                                w_data_next  = {w_bit, r_shift[7:1]};
                            end
                        end
                    end else if (w_is_se0) begin
                        w_state_next = S_EOP;
                    end else begin
                        w_error_next    = 1'b1;
                        w_active_next   = 1'b0;
                        w_se0_seen_next = 1'b0;
                        w_state_next    = S_ABORT;
                    end
                end

                S_EOP: begin
                    if (w_is_j) begin
                        w_eop_next    = 1'b1;
                        w_error_next  = (r_bit_cnt != 3'd0);
                        w_active_next = 1'b0;
                        w_state_next  = S_IDLE;
                    end else if (!w_is_se0) begin
                        w_error_next    = 1'b1;
                        w_active_next   = 1'b0;
                        w_se0_seen_next = 1'b0;
                        w_state_next    = S_ABORT;
                    end
                end

                S_ABORT: begin
                    if (w_is_se0) begin
                        w_se0_seen_next = 1'b1;
                    end else if (w_is_j && r_se0_seen) begin
                        w_state_next = S_IDLE;
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    assign rx_active = r_rx_active;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign rx_eop    = r_rx_eop;
    assign rx_error  = r_rx_error;
    assign bus_reset = (r_se0_cnt == RESET_LIMIT);

endmodule

// File: tb/tb_usb_fs_rx.sv
// Directed bench for usb_fs_rx: drives NRZI line patterns and compares the
// recorded strobe stream against hand-computed expectations.
module tb_usb_fs_rx;

    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       usb_d_p, usb_d_n;
    logic       rx_active, rx_valid, rx_eop, rx_error, bus_reset;
    logic [7:0] rx_data;

    always #10 sys_clk = ~sys_clk;

    usb_fs_rx #(.RESET_CYCLES(120)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .usb_d_p   (usb_d_p),
        .usb_d_n   (usb_d_n),
        .rx_active (rx_active),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_eop    (rx_eop),
        .rx_error  (rx_error),
        .bus_reset (bus_reset)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event record: {valid, eop, error, data (zero unless valid)}
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    int          n_active = 0;
    int          n_wide   = 0;
    logic        act_at_err = 1'b1;
    logic        p_v = 1'b0, p_e = 1'b0, p_r = 1'b0;

    always @(negedge sys_clk) begin
        if (rx_valid === 1'b1 || rx_eop === 1'b1 || rx_error === 1'b1)
            log_q.push_back({rx_valid, rx_eop, rx_error, (rx_valid === 1'b1) ? rx_data : 8'h00});
        if (rx_active === 1'b1) n_active++;
        if (rx_error === 1'b1) act_at_err = rx_active;
        if ((rx_valid === 1'b1 && p_v) || (rx_eop === 1'b1 && p_e) || (rx_error === 1'b1 && p_r))
            n_wide++;
        p_v = (rx_valid === 1'b1);
        p_e = (rx_eop === 1'b1);
        p_r = (rx_error === 1'b1);
    end

    // Line encoder state
    int   g_skew  = 5;
    logic tb_jk   = 1'b1;
    int   tb_ones = 0;
    bit   stuff_en = 1'b1;
    bit   jit_en  = 1'b0;
    int   jit_idx = 0;
    int   j_prev  = 0;
    int   jit_pat [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

    task automatic drive(input logic [1:0] st, input int clocks);
        {usb_d_p, usb_d_n} = st;
        repeat (clocks) @(posedge sys_clk);
        #(g_skew);
    endtask

    task automatic put_level(input logic [1:0] st);
        int dur;
        int jn;
        dur = 4;
        if (jit_en) begin
            jn = jit_pat[jit_idx % 8];
            jit_idx++;
            dur = 4 + jn - j_prev;
            j_prev = jn;
        end
        drive(st, dur);
    endtask

    task automatic send_raw_bit(input logic b);
        if (!b) tb_jk = ~tb_jk;
        put_level(tb_jk ? J : K);
    endtask

    task automatic send_bit(input logic b);
        send_raw_bit(b);
        if (b) begin
            tb_ones++;
            if (stuff_en && tb_ones == 6) begin
                send_raw_bit(1'b0);
                tb_ones = 0;
            end
        end else begin
            tb_ones = 0;
        end
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
        send_raw_bit(1'b1);
        tb_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic idle(input int nbits);
        tb_jk = 1'b1;
        for (int i = 0; i < nbits; i++) put_level(J);
    endtask

    task automatic send_eop();
        put_level(SE0);
        put_level(SE0);
        idle(5);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        {usb_d_p, usb_d_n} = J;
        repeat (3) @(posedge sys_clk);
        #(g_skew);
        n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got=%b exp=0", rx_active); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_checks++; if (rx_eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop got=%b exp=0", rx_eop); end
        n_checks++; if (rx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", rx_error); end
        n_checks++; if (bus_reset !== 1'b0) begin n_fail++; $display("FAIL reset_bus_reset got=%b exp=0", bus_reset); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        sys_rst = 1'b0;
        idle(4);
    endtask

    task automatic test_basic();
        int base;
        int act0;
        base = log_q.size();
        act0 = n_active;
        send_sync();
        send_byte(8'hC3);
        send_eop();
        exp_q = '{11'h4C3, 11'h200};
        n_checks++;
        if ((log_q.size() - base) !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_event%0d got=%h exp=%h", i, log_q[base + i], exp_q[i]); end
        end
        n_checks++; if ((n_active > act0) !== 1'b1) begin n_fail++; $display("FAIL basic_active_seen got=%0d exp=>0", n_active - act0); end
        n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL basic_active_end got=%b exp=0", rx_active); end
    endtask

    task automatic test_stuff();
        int base;
        base = log_q.size();
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h01);
        send_eop();
        exp_q = '{11'h4FF, 11'h401, 11'h200};
        n_checks++;
        if ((log_q.size() - base) !== exp_q.size()) begin
            n_fail++; $display("FAIL stuff_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL stuff_event%0d got=%h exp=%h", i, log_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_stuff_error();
        int base;
        base = log_q.size();
        send_sync();
        stuff_en = 1'b0;
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_byte(8'h00);
        stuff_en = 1'b1;
        n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL stuff_err_active got=%b exp=0", rx_active); end
        send_eop();
        send_sync();
        send_byte(8'h5A);
        send_eop();
        exp_q = '{11'h100, 11'h45A, 11'h200};
        n_checks++;
        if ((log_q.size() - base) !== exp_q.size()) begin
            n_fail++; $display("FAIL stuff_err_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL stuff_err_event%0d got=%h exp=%h", i, log_q[base + i], exp_q[i]); end
        end
        n_checks++; if (act_at_err !== 1'b0) begin n_fail++; $display("FAIL stuff_err_active_at_strobe got=%b exp=0", act_at_err); end
    endtask

    task automatic test_partial();
        int base;
        base = log_q.size();
        send_sync();
        send_byte(8'hA5);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop();
        exp_q = '{11'h4A5, 11'h300};
        n_checks++;
        if ((log_q.size() - base) !== exp_q.size()) begin
            n_fail++; $display("FAIL partial_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL partial_event%0d got=%h exp=%h", i, log_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_bus_reset();
        int base;
        int rise_i;
        int fall_i;
        base = log_q.size();
        rise_i = -1;
        fall_i = -1;
        @(posedge sys_clk);
        #2;
        {usb_d_p, usb_d_n} = SE0;
        for (int i = 1; i <= 260; i++) begin
            @(posedge sys_clk);
            if (i == 200) begin
                #2;
                {usb_d_p, usb_d_n} = J;
            end
            @(negedge sys_clk);
            if (bus_reset === 1'b1 && rise_i < 0) rise_i = i;
            if (bus_reset !== 1'b1 && rise_i >= 0 && fall_i < 0) fall_i = i;
        end
        #(g_skew);
        idle(2);
        n_checks++; if (rise_i !== 122) begin n_fail++; $display("FAIL bus_reset_rise got=%0d exp=122", rise_i); end
        n_checks++; if (fall_i !== 203) begin n_fail++; $display("FAIL bus_reset_fall got=%0d exp=203", fall_i); end
        n_checks++; if ((log_q.size() - base) !== 0) begin n_fail++; $display("FAIL bus_reset_strobes got=%0d exp=0", log_q.size() - base); end
    endtask

    task automatic test_mid_reset();
        int base;
        base = log_q.size();
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_checks++; if (rx_active !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre_active got=%b exp=1", rx_active); end
        sys_rst = 1'b1;
        repeat (3) @(posedge sys_clk);
        #(g_skew);
        n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL mid_reset_active got=%b exp=0", rx_active); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data got=%h exp=00", rx_data); end
        n_checks++; if (bus_reset !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bus_reset got=%b exp=0", bus_reset); end
        sys_rst = 1'b0;
        send_eop();
        send_sync();
        send_byte(8'h81);
        send_eop();
        exp_q = '{11'h481, 11'h200};
        n_checks++;
        if ((log_q.size() - base) !== exp_q.size()) begin
            n_fail++; $display("FAIL mid_reset_count got=%0d exp=%0d", log_q.size() - base, exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_reset_event%0d got=%h exp=%h", i, log_q[base + i], exp_q[i]); end
        end
    endtask

    task automatic test_jitter();
        int base;
        for (int off = 0; off < 4; off++) begin
            g_skew = 3 + 5 * off;
            drive(J, 4 + off);
            jit_en = 1'b1;
            j_prev = 0;
            base = log_q.size();
            send_sync();
            send_byte(8'h3C);
            send_byte(8'h96);
            send_eop();
            jit_en = 1'b0;
            exp_q = '{11'h43C, 11'h496, 11'h200};
            n_checks++;
            if ((log_q.size() - base) !== exp_q.size()) begin
                n_fail++; $display("FAIL jitter%0d_count got=%0d exp=%0d", off, log_q.size() - base, exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (log_q[base + i] !== exp_q[i]) begin n_fail++; $display("FAIL jitter%0d_event%0d got=%h exp=%h", off, i, log_q[base + i], exp_q[i]); end
            end
        end
        g_skew = 5;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stuff();
        test_stuff_error();
        test_partial();
        test_bus_reset();
        test_mid_reset();
        test_jitter();
        n_checks++; if (n_wide !== 0) begin n_fail++; $display("FAIL strobe_width got=%0d exp=0", n_wide); end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
